// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding and default latencies.
package mdu_pkg;

  localparam int OP_W = 4;
  localparam int CNT_W = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO; results are computed at accept and
// committed after a fixed latency while busy is held.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mdu_ans_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, quo_s, rem_s, quo_u, rem_u;
  logic        div_zero;

  // Divisor forced to 1 on zero so the divider never sees /0; the result is discarded anyway.
  assign div_zero = (rt_val_i == 32'd0);
  assign divisor  = div_zero ? 32'd1 : rt_val_i;
  assign prod_s   = $signed({{32{rs_val_i[31]}}, rs_val_i}) * $signed({{32{rt_val_i[31]}}, rt_val_i});
  assign prod_u   = {32'd0, rs_val_i} * {32'd0, rt_val_i};
  assign quo_s    = $signed(rs_val_i) / $signed(divisor);
  assign rem_s    = $signed(rs_val_i) % $signed(divisor);
  assign quo_u    = rs_val_i / divisor;
  assign rem_u    = rs_val_i % divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (op_i == OP_MULT) ? prod_s : prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = (op_i == OP_DIV) ? rem_s : rem_u;
              pend_lo_d = (op_i == OP_DIV) ? quo_s : quo_u;
              pend_wr_d = !div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = rs_val_i;
            OP_MTLO: lo_d = rs_val_i;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o    = (state_q == ST_RUN);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mdu_ans_o = (op_i == OP_MFHI) ? hi_q :
                     (op_i == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized traffic
// against a time-stamped transaction model of HI/LO.
module tb_mdu;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] rs_val_i = '0, rt_val_i = '0;
  logic        busy_o;
  logic [31:0] hi_o, lo_o, mdu_ans_o;

  int checks = 0;
  int errors = 0;

  // Model: architectural HI/LO plus the edge index at which the in-flight op commits.
  longint      edge_n = 0;
  longint      done_at = -1;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 0;

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_val_i(rs_val_i), .rt_val_i(rt_val_i), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .mdu_ans_o(mdu_ans_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy(input longint after_edge);
    return after_edge < done_at;
  endfunction

  task automatic model_edge();
    longint      sp, up;
    int          a, b;
    bit          was_busy;
    edge_n++;
    if (reset) begin
      m_hi = '0; m_lo = '0; done_at = -1; p_wr = 0;
      return;
    end
    was_busy = m_busy(edge_n - 1);
    if (was_busy && edge_n == done_at && p_wr) begin
      m_hi = p_hi; m_lo = p_lo;
    end
    if (start_i && !was_busy) begin
      a  = int'(rs_val_i);
      b  = int'(rt_val_i);
      sp = longint'(a) * longint'(b);
      up = longint'({32'd0, rs_val_i}) * longint'({32'd0, rt_val_i});
      case (op_i)
        4'd1: begin {p_hi, p_lo} = sp; p_wr = 1; done_at = edge_n + NM; end
        4'd2: begin {p_hi, p_lo} = up; p_wr = 1; done_at = edge_n + NM; end
        4'd3: begin
          p_wr = (b != 0);
          if (b != 0) begin p_lo = a / b; p_hi = a % b; end
          done_at = edge_n + ND;
        end
        4'd4: begin
          p_wr = (b != 0);
          if (b != 0) begin p_lo = rs_val_i / rt_val_i; p_hi = rs_val_i % rt_val_i; end
          done_at = edge_n + ND;
        end
        4'd7: m_hi = rs_val_i;
        4'd8: m_lo = rs_val_i;
        default: ;
      endcase
    end
  endtask

  // Checks the combinational read for the op currently driven, clocks once, then checks state.
  task automatic tick();
    logic [31:0] ans;
    #1;
    ans = (op_i == 4'd5) ? m_hi : (op_i == 4'd6) ? m_lo : 32'd0;
    chk("mdu_ans", mdu_ans_o, ans);
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", busy_o, m_busy(edge_n));
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int busy_len);
    start_i = 1'b1; op_i = op; rs_val_i = rs; rt_val_i = rt;
    tick();
    start_i = 1'b0; op_i = 4'd0;
    busy_len = 0;
    while (busy_o && busy_len < 40) begin
      busy_len++;
      tick();
    end
  endtask

  int n;
  logic [31:0] r1, r2;

  initial begin
    tick(); tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    reset = 1'b0;

    issue(4'd1, 32'hFFFFFFFD, 32'd5, n);
    chk("mult_busy_len", n, NM);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFF1);

    issue(4'd2, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_hi", hi_o, 32'h00000001);
    chk("multu_lo", lo_o, 32'hFFFFFFFE);
    op_i = 4'd6; start_i = 1'b1; #1;
    chk("mflo_ans", mdu_ans_o, 32'hFFFFFFFE);
    op_i = 4'd5; #1;
    chk("mfhi_ans", mdu_ans_o, 32'h00000001);
    tick();
    start_i = 1'b0; op_i = 4'd0;

    issue(4'd3, 32'hFFFFFFF9, 32'd2, n);
    chk("div_busy_len", n, ND);
    chk("div_lo", lo_o, 32'hFFFFFFFD);
    chk("div_hi", hi_o, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd2, n);
    chk("divu_lo", lo_o, 32'd3);
    chk("divu_hi", hi_o, 32'd1);

    issue(4'd7, 32'h1234, 32'd0, n);
    chk("mthi_nobusy", n, 0);
    issue(4'd8, 32'h5678, 32'd0, n);
    issue(4'd3, 32'd9, 32'd0, n);
    chk("div0_busy_len", n, ND);
    chk("div0_hi", hi_o, 32'h1234);
    chk("div0_lo", lo_o, 32'h5678);

    start_i = 1'b1; op_i = 4'd1; rs_val_i = 32'd3; rt_val_i = 32'd4;
    tick();
    start_i = 1'b0; op_i = 4'd0; rs_val_i = 32'hDEAD; rt_val_i = 32'hBEEF;
    tick();
    start_i = 1'b1; op_i = 4'd4; rs_val_i = 32'd100; rt_val_i = 32'd7;
    tick();
    start_i = 1'b0; op_i = 4'd0;
    n = 0;
    while (busy_o && n < 40) begin n++; tick(); end
    chk("ignored_busy_len", n, NM - 2);
    chk("ignored_hi", hi_o, 32'd0);
    chk("ignored_lo", lo_o, 32'd12);
    tick(); tick();
    chk("ignored_no_div", busy_o, 1'b0);

    start_i = 1'b1; op_i = 4'd1; rs_val_i = 32'h10000; rt_val_i = 32'h10000;
    tick();
    start_i = 1'b0; op_i = 4'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", busy_o, 1'b0);
    chk("rstmid_hi", hi_o, 32'd0);
    chk("rstmid_lo", lo_o, 32'd0);
    repeat (8) tick();
    chk("rstmid_nocommit_hi", hi_o, 32'd0);
    chk("rstmid_nocommit_lo", lo_o, 32'd0);

    reset = 1'b1; start_i = 1'b1; op_i = 4'd7; rs_val_i = 32'hCAFE;
    tick();
    reset = 1'b0; start_i = 1'b0; op_i = 4'd0;
    chk("rst_prio_hi", hi_o, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      case ($urandom_range(0, 3))
        0: r2 = 32'd0;
        1: r2 = $urandom_range(0, 9);
        2: r1 = $urandom_range(0, 200) - 100;
        default: ;
      endcase
      if (r1 == 32'h80000000 && r2 == 32'hFFFFFFFF) r2 = 32'd3;
      start_i  = ($urandom_range(0, 1) == 1);
      op_i     = 4'($urandom_range(0, 15));
      rs_val_i = r1;
      rt_val_i = r2;
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; start_i = 1'b0; op_i = 4'd0;
    repeat (ND + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage of the 5-stage pipeline. It owns the HI/LO architectural registers and runs MULT, MULTU, DIV and DIVU as fixed-latency multi-cycle operations with a busy flag. It also services MTHI/MTLO writes and MFHI/MFLO reads. The read value is carried down the pipeline as the mdu result and reaches writeback through the M/W register.

## Interface
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU; legal range 1..15
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU; legal range 1..15
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is an MDU instruction, valid this cycle
- op  in  4  MDU operation code (shared package encoding)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  multi-cycle operation in flight
- hi  out  32  current HI register
- lo  out  32  current LO register
- mdu_ans  out  32  MFHI→hi, MFLO→lo, otherwise 0 (combinational)

## Operation
- Reset values: hi=0, lo=0, busy=0, counter=0, pending results=0.
- Op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9..15 behave as NONE.
- Accept condition: start && !busy. While busy, start is ignored. The hazard unit stalls D on (start||busy) for MDU instructions, so this case is illegal for software but must be safe.
- MULT: 64-bit signed product of rs_val×rt_val. MULTU: unsigned product. Pending {hi,lo} = product.
- DIV: signed division. Quotient is truncated toward zero and goes to lo. Remainder takes the sign of the dividend and goes to hi.
- DIVU: unsigned division, quotient→lo, remainder→hi.
- DIV/DIVU with rt_val=0: operation still runs full DIV_CYCLES with busy asserted. HI/LO are left unchanged at completion.
- The result is computed combinationally at accept and latched into pending registers. Iterative dividers are not used.
- MTHI/MTLO: on accept, rs_val→hi or rs_val→lo at that edge. No busy.
- MFHI/MFLO: no state change. mdu_ans reflects the op on the same cycle.
- States: IDLE (busy=0) and RUN (busy=1, counter>0).
- IDLE→RUN on accepted MULT* (counter=MULT_CYCLES) or DIV* (counter=DIV_CYCLES).
- In RUN, counter decrements each cycle. When counter==1, the next edge commits pending to hi/lo, clears busy and returns to IDLE.

## Timing
- Accept at edge t: busy=1 from t through t+N-1 (N = MULT_CYCLES or DIV_CYCLES), with N edges counted. HI/LO update on edge t+N. busy=0 after t+N.
- A new MDU op is accepted in the first cycle busy reads 0. Back-to-back ops have no bubble beyond N.
- mdu_ans is combinational from op/hi/lo, with zero latency. MFHI issued the cycle after completion reads the new value.
- Reset asserted mid-operation: the pending result is discarded. hi=lo=0 and busy=0 on that edge.
- Reset has priority over start on the same edge.
- Operand changes after accept have no effect on the in-flight result.

## Structure
- Shared package (mdu_pkg): op encoding constants, default latency constants, op width.
- A single module with no sub-modules. The datapath is a combinational product/quotient/remainder block, the controller is a counter plus a busy flag.

## Test plan
- Signed multiply: MULT rs=0xFFFFFFFD (−3), rt=5.
  - busy high 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned multiply: MULTU rs=0xFFFFFFFF, rt=2.
  - hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
  - MFLO then gives mdu_ans=0xFFFFFFFE.
- Signed and unsigned divide:
  - DIV rs=0xFFFFFFF9 (−7), rt=2: busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2: lo=3, hi=1.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV rs=9, rt=0.
  - busy 10 cycles.
  - hi=0x1234, lo=0x5678 unchanged.
- Start while busy: MULT 3×4, then start=1 with DIVU 100/7 two cycles later.
  - The DIVU is ignored.
  - hi=0, lo=12 at completion.
- Reset mid-operation: MULT 0x10000×0x10000, reset at cycle 3.
  - busy=0, hi=0, lo=0 on the reset edge.
  - No later commit occurs.
